// File: rtl/micro_sequencer.sv
// Microprogrammed controller for the 4-bit ALU/GRS/shifter datapath, with a writable control store.
// Optional build macro SEQ_SINGLE_STEP_EN: UPC and the register clock enables advance only when i_step is high.
module micro_sequencer #(
   parameter  int UAW = 4,
   localparam int MW  = 19 + UAW
) (
   input  logic           i_clk,
   input  logic           i_rst_n,
   input  logic           i_start,
   input  logic [UAW-1:0] i_startAddr,
   input  logic           i_abort,
   input  logic           i_step,
   input  logic           i_ldWe,
   input  logic [UAW-1:0] i_ldAddr,
   input  logic [MW-1:0]  i_ldData,
   input  logic [3:0]     i_psw,
   output logic           o_ace,
   output logic           o_grsCe,
   output logic           o_pswCe,
   output logic [1:0]     o_stOp,
   output logic [3:0]     o_aluOp,
   output logic           o_dataOe,
   output logic           o_grsOe,
   output logic           o_sOe,
   output logic [1:0]     o_index,
   output logic [UAW-1:0] o_upc,
   output logic           o_busy,
   output logic           o_done,
   output logic           o_err
);
   typedef enum logic {IDLE, RUN} stateT;

   localparam logic [1:0] SEQ_NEXT   = 2'b00;
   localparam logic [1:0] SEQ_JUMP   = 2'b01;
   localparam logic [1:0] SEQ_BRANCH = 2'b10;
   localparam logic [1:0] SEQ_HALT   = 2'b11;

   stateT          r_state;
   logic [UAW-1:0] r_upc;
   logic           r_busy;
   logic           r_done;
   logic           r_err;
   logic [MW-1:0]  r_store [2**UAW];

   logic [MW-1:0]  w_word;
   logic [1:0]     w_seq;
   logic [1:0]     w_csel;
   logic [UAW-1:0] w_target;
   logic [UAW-1:0] w_nextUpc;
   logic           w_exec;
   logic           w_contention;
   logic           w_advance;
   logic           w_unused;

   assign w_word   = r_store[r_upc];
   assign w_seq    = w_word[MW-1 -: 2];
   assign w_csel   = w_word[MW-3 -: 2];
   assign w_target = w_word[MW-5 -: UAW];
   assign w_exec   = (r_state == RUN) && !i_abort && (w_seq != SEQ_HALT);
   assign w_contention = (w_word[5] & w_word[4]) | (w_word[5] & w_word[3]) | (w_word[4] & w_word[3]);

`ifdef SEQ_SINGLE_STEP_EN
   assign w_advance = i_step;
   assign w_unused  = w_word[0];
`else
   assign w_advance = 1'b1;
   assign w_unused  = ^{w_word[0], i_step};
`endif

   assign o_upc  = r_upc;
   assign o_busy = r_busy;
   assign o_done = r_done;
   assign o_err  = r_err;

   always_comb begin
      w_nextUpc = r_upc + UAW'(1);
      case (w_seq)
         SEQ_JUMP:   w_nextUpc = w_target;
         SEQ_BRANCH: if (i_psw[w_csel]) w_nextUpc = w_target;
         default:    ;
      endcase
   end

   // The datapath samples these at the same edge that retires the word, so they must be combinational.
   always_comb begin
      o_ace    = 1'b0;
      o_grsCe  = 1'b0;
      o_pswCe  = 1'b0;
      o_stOp   = 2'b00;
      o_aluOp  = 4'h0;
      o_dataOe = 1'b0;
      o_grsOe  = 1'b0;
      o_sOe    = 1'b0;
      o_index  = 2'b00;
      if (w_exec) begin
         o_ace   = w_word[14] & w_advance;
         o_grsCe = w_word[13] & w_advance;
         o_pswCe = w_word[12] & w_advance;
         o_stOp  = w_word[11:10];
         o_aluOp = w_word[9:6];
         o_index = w_word[2:1];
         if (!w_contention) begin
            o_dataOe = w_word[5];
            o_grsOe  = w_word[4];
            o_sOe    = w_word[3];
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= IDLE;
         r_upc   <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_err   <= 1'b0;
         for (int i = 0; i < 2**UAW; i++) r_store[i] <= '0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (i_ldWe) r_store[i_ldAddr] <= i_ldData;
               if (i_start) begin
                  r_upc   <= i_startAddr;
                  r_err   <= 1'b0;
                  r_busy  <= 1'b1;
                  r_state <= RUN;
               end
            end
            RUN: begin
               if (i_abort) begin
                  r_busy  <= 1'b0;
                  r_state <= IDLE;
               end else if (w_seq == SEQ_HALT) begin
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                  r_state <= IDLE;
               end else begin
                  if (w_contention) r_err <= 1'b1;
                  if (w_advance) r_upc <= w_nextUpc;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_micro_sequencer.sv
// Self-checking bench for micro_sequencer: a vector table plus hand-written multi-cycle sequences, checked via a scoreboard queue.
module tb_micro_sequencer;
   localparam logic [1:0] S_NEXT = 2'b00;
   localparam logic [1:0] S_JUMP = 2'b01;
   localparam logic [1:0] S_BR   = 2'b10;
   localparam logic [1:0] S_HALT = 2'b11;

   localparam logic [13:0] Z       = 14'h0;
   localparam logic [13:0] C_ACE   = 14'b10_0000_0000_0000;
   localparam logic [13:0] C_GRSCE = 14'b01_0000_0000_0000;
   localparam logic [13:0] C_PSWCE = 14'b00_1000_0000_0000;
   localparam logic [13:0] C_DATAOE= 14'b00_0000_0001_0000;
   localparam logic [13:0] C_GRSOE = 14'b00_0000_0000_1000;
   localparam logic [13:0] C_SOE   = 14'b00_0000_0000_0100;

   typedef struct packed {
      logic [13:0] ctrl;
      logic [3:0]  upc;
      logic        busy;
      logic        done;
      logic        err;
   } expT;

   typedef struct packed {
      logic        rstN;
      logic        start;
      logic [3:0]  sAddr;
      logic        abort;
      logic        step;
      logic        ldWe;
      logic [3:0]  ldAddr;
      logic [22:0] ldData;
      logic [3:0]  psw;
      expT         want;
   } vecT;

   logic        clk = 1'b0;
   logic        rstN, start, abort, step, ldWe;
   logic [3:0]  sAddr, ldAddr, psw;
   logic [22:0] ldData;
   logic        ace, grsCe, pswCe, dataOe, grsOe, sOe, busy, done, err;
   logic [1:0]  stOp, index;
   logic [3:0]  aluOp, upc;

   int  compared   = 0;
   int  mismatched = 0;
   expT scoreboard[$];
   vecT tbl[17];
   vecT v;

   micro_sequencer #(.UAW(4)) dut (
      .i_clk(clk), .i_rst_n(rstN), .i_start(start), .i_startAddr(sAddr),
      .i_abort(abort), .i_step(step), .i_ldWe(ldWe), .i_ldAddr(ldAddr),
      .i_ldData(ldData), .i_psw(psw),
      .o_ace(ace), .o_grsCe(grsCe), .o_pswCe(pswCe), .o_stOp(stOp), .o_aluOp(aluOp),
      .o_dataOe(dataOe), .o_grsOe(grsOe), .o_sOe(sOe), .o_index(index),
      .o_upc(upc), .o_busy(busy), .o_done(done), .o_err(err)
   );

   always #5 clk = ~clk;

   function automatic logic [22:0] mkWord(input logic [1:0] seq, input logic [1:0] csel,
                                          input logic [3:0] target, input logic [13:0] ctrl);
      return {seq, csel, target, ctrl, 1'b1};
   endfunction

   function automatic logic [13:0] alu(input logic [3:0] a);
      return {5'b0, a, 5'b0};
   endfunction

   function automatic logic [13:0] idx(input logic [1:0] i);
      return {12'b0, i};
   endfunction

   function automatic vecT mk(input logic st, input logic [3:0] sa, input logic ab,
                              input logic we, input logic [3:0] la, input logic [22:0] ld,
                              input logic [3:0] p, input logic [13:0] c, input logic [3:0] u,
                              input logic b, input logic d, input logic e);
      vecT r;
      r.rstN = 1'b1; r.start = st; r.sAddr = sa; r.abort = ab; r.step = 1'b1;
      r.ldWe = we; r.ldAddr = la; r.ldData = ld; r.psw = p;
      r.want.ctrl = c; r.want.upc = u; r.want.busy = b; r.want.done = d; r.want.err = e;
      return r;
   endfunction

   // Compares the DUT against the oldest scoreboard entry.
   task automatic checkOutput(input string name);
      expT want, got;
      got = '{ctrl: {ace, grsCe, pswCe, stOp, aluOp, dataOe, grsOe, sOe, index},
               upc: upc, busy: busy, done: done, err: err};
      compared++;
      if (scoreboard.size() == 0) begin
         mismatched++;
         $display("[TB] FAIL %s: scoreboard empty", name);
      end else begin
         want = scoreboard.pop_front();
         if (got !== want) begin
            mismatched++;
            $display("[TB] FAIL %s: got ctrl=%h upc=%0d busy=%b done=%b err=%b, expected ctrl=%h upc=%0d busy=%b done=%b err=%b",
                     name, got.ctrl, got.upc, got.busy, got.done, got.err,
                     want.ctrl, want.upc, want.busy, want.done, want.err);
         end
      end
   endtask

   // Drives one cycle of inputs just after the rising edge and checks on the falling edge.
   task automatic applyStimulus(input vecT s, input string name);
      rstN = s.rstN; start = s.start; sAddr = s.sAddr; abort = s.abort; step = s.step;
      ldWe = s.ldWe; ldAddr = s.ldAddr; ldData = s.ldData; psw = s.psw;
      scoreboard.push_back(s.want);
      @(negedge clk);
      checkOutput(name);
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [22:0] w0, w1, w3, wHalt, w15, w0b, w5, w7, w10;
      w0    = mkWord(S_NEXT, 2'd0, 4'd0,  C_DATAOE | C_ACE | alu(4'h5));
      w1    = mkWord(S_HALT, 2'd0, 4'd0,  C_ACE | C_DATAOE);
      w3    = mkWord(S_BR,   2'd0, 4'd9,  C_PSWCE | alu(4'hA) | C_GRSOE | idx(2'd2));
      wHalt = mkWord(S_HALT, 2'd0, 4'd0,  Z);
      w15   = mkWord(S_NEXT, 2'd0, 4'd0,  C_SOE | idx(2'd3));
      w0b   = mkWord(S_JUMP, 2'd0, 4'd15, C_GRSCE);
      w5    = mkWord(S_NEXT, 2'd0, 4'd0,  C_GRSOE | C_SOE | C_GRSCE | alu(4'h3));
      w7    = mkWord(S_JUMP, 2'd0, 4'd7,  C_ACE);
      w10   = mkWord(S_NEXT, 2'd0, 4'd0,  C_ACE | C_DATAOE);

      rstN = 1'b0; start = 0; sAddr = 0; abort = 0; step = 1; ldWe = 0; ldAddr = 0; ldData = 0; psw = 0;
      repeat (2) @(posedge clk);
      #1;

      tbl[0]  = mk(0, 0, 0, 0, 0, 0,     0, Z, 0, 0, 0, 0);
      tbl[0].rstN = 1'b0;
      tbl[1]  = mk(0, 0, 0, 0, 0, 0,     0, Z, 0, 0, 0, 0);
      tbl[2]  = mk(0, 0, 0, 1, 1, w1,    0, Z, 0, 0, 0, 0);
      tbl[3]  = mk(1, 0, 0, 1, 0, w0,    0, Z, 0, 0, 0, 0);
      tbl[4]  = mk(0, 0, 0, 0, 0, 0,     0, C_DATAOE | C_ACE | alu(4'h5), 0, 1, 0, 0);
      tbl[5]  = mk(0, 0, 0, 0, 0, 0,     0, Z, 1, 1, 0, 0);
      tbl[6]  = mk(0, 0, 0, 0, 0, 0,     0, Z, 1, 0, 1, 0);
      tbl[7]  = mk(0, 0, 0, 1, 3, w3,    0, Z, 1, 0, 0, 0);
      tbl[8]  = mk(0, 0, 0, 1, 9, wHalt, 0, Z, 1, 0, 0, 0);
      tbl[9]  = mk(1, 3, 0, 1, 4, wHalt, 1, Z, 1, 0, 0, 0);
      tbl[10] = mk(0, 0, 0, 0, 0, 0,     1, C_PSWCE | alu(4'hA) | C_GRSOE | idx(2'd2), 3, 1, 0, 0);
      tbl[11] = mk(0, 0, 0, 0, 0, 0,     1, Z, 9, 1, 0, 0);
      tbl[12] = mk(0, 0, 0, 0, 0, 0,     0, Z, 9, 0, 1, 0);
      tbl[13] = mk(1, 3, 0, 0, 0, 0,     0, Z, 9, 0, 0, 0);
      tbl[14] = mk(0, 0, 0, 0, 0, 0,     0, C_PSWCE | alu(4'hA) | C_GRSOE | idx(2'd2), 3, 1, 0, 0);
      tbl[15] = mk(0, 0, 0, 0, 0, 0,     0, Z, 4, 1, 0, 0);
      tbl[16] = mk(0, 0, 0, 0, 0, 0,     0, Z, 4, 0, 1, 0);
      for (int i = 0; i < 17; i++) applyStimulus(tbl[i], $sformatf("vec%0d", i));

      // Wrap 15->0, JUMP loop back to 15, START ignored while running, ABORT without DONE.
      applyStimulus(mk(0, 0,  0, 1, 15, w15, 0, Z, 4, 0, 0, 0), "wrapLd15");
      applyStimulus(mk(1, 15, 0, 1, 0,  w0b, 0, Z, 4, 0, 0, 0), "wrapLd0Start");
      applyStimulus(mk(0, 0,  0, 0, 0, 0, 0, C_SOE | idx(2'd3), 15, 1, 0, 0), "wrapAt15");
      applyStimulus(mk(1, 5,  0, 0, 0, 0, 0, C_GRSCE, 0, 1, 0, 0), "wrapAt0StartIgnored");
      applyStimulus(mk(0, 0,  0, 0, 0, 0, 0, C_SOE | idx(2'd3), 15, 1, 0, 0), "jumpBack15");
      applyStimulus(mk(0, 0,  0, 0, 0, 0, 0, C_GRSCE, 0, 1, 0, 0), "loopAt0");
      applyStimulus(mk(0, 0,  1, 0, 0, 0, 0, Z, 15, 1, 0, 0), "abortCycle");
      applyStimulus(mk(0, 0,  0, 0, 0, 0, 0, Z, 15, 0, 0, 0), "abortNoDone");
      applyStimulus(mk(0, 0,  1, 0, 0, 0, 0, Z, 15, 0, 0, 0), "abortInIdle");

      // Bus contention: oe suppressed, ce passes, ERR sticky until the next START.
      applyStimulus(mk(0, 0, 0, 1, 5, w5,    0, Z, 15, 0, 0, 0), "contLd5");
      applyStimulus(mk(1, 5, 0, 1, 6, wHalt, 0, Z, 15, 0, 0, 0), "contLd6Start");
      applyStimulus(mk(0, 0, 0, 0, 0, 0, 0, C_GRSCE | alu(4'h3), 5, 1, 0, 0), "contOeForced");
      applyStimulus(mk(0, 0, 0, 0, 0, 0, 0, Z, 6, 1, 0, 1), "contErrSet");
      applyStimulus(mk(0, 0, 0, 0, 0, 0, 0, Z, 6, 0, 1, 1), "contErrHeld");
      applyStimulus(mk(1, 6, 0, 0, 0, 0, 0, Z, 6, 0, 0, 1), "contErrAtStart");
      applyStimulus(mk(0, 0, 0, 0, 0, 0, 0, Z, 6, 1, 0, 0), "contErrCleared");
      applyStimulus(mk(0, 0, 0, 0, 0, 0, 0, Z, 6, 0, 1, 0), "contDone");

      // A write during RUN must be dropped; a reset mid-run clears state and store.
      applyStimulus(mk(0, 0, 0, 1, 7, w7, 0, Z, 6, 0, 0, 0), "ldLd7");
      applyStimulus(mk(1, 7, 0, 0, 0, 0,  0, Z, 6, 0, 0, 0), "ldStart7");
      applyStimulus(mk(0, 0, 0, 1, 2, mkWord(S_NEXT, 2'd0, 4'd0, C_DATAOE), 0, C_ACE, 7, 1, 0, 0), "ldWriteWhileBusy");
      applyStimulus(mk(0, 0, 1, 0, 0, 0, 0, Z, 7, 1, 0, 0), "ldAbort");
      applyStimulus(mk(1, 2, 0, 0, 0, 0, 0, Z, 7, 0, 0, 0), "ldStart2");
      applyStimulus(mk(0, 0, 0, 0, 0, 0, 0, Z, 2, 1, 0, 0), "ldStoreUnchanged");
      applyStimulus(mk(0, 0, 0, 0, 0, 0, 0, C_PSWCE | alu(4'hA) | C_GRSOE | idx(2'd2), 3, 1, 0, 0), "ldNextTo3");
      applyStimulus(mk(0, 0, 0, 0, 0, 0, 0, Z, 4, 1, 0, 0), "ldHalt4");
      applyStimulus(mk(0, 0, 0, 0, 0, 0, 0, Z, 4, 0, 1, 0), "ldDone");
      applyStimulus(mk(1, 7, 0, 0, 0, 0, 0, Z, 4, 0, 0, 0), "rstStart7");
      applyStimulus(mk(0, 0, 0, 0, 0, 0, 0, C_ACE, 7, 1, 0, 0), "rstRunning");
      v = mk(0, 0, 0, 0, 0, 0, 0, Z, 0, 0, 0, 0);
      v.rstN = 1'b0;
      applyStimulus(v, "rstMidRun");
      applyStimulus(mk(1, 7, 0, 0, 0, 0, 0, Z, 0, 0, 0, 0), "rstReleaseStart");
      applyStimulus(mk(0, 0, 0, 0, 0, 0, 0, Z, 7, 1, 0, 0), "rstStoreCleared");
      applyStimulus(mk(0, 0, 1, 0, 0, 0, 0, Z, 8, 1, 0, 0), "rstNextAbort");
      applyStimulus(mk(0, 0, 0, 0, 0, 0, 0, Z, 8, 0, 0, 0), "rstIdle");

`ifdef SEQ_SINGLE_STEP_EN
      // Single step: UPC and ce held while STEP is low, oe still driven.
      applyStimulus(mk(0, 0,  0, 1, 10, w10,   0, Z, 8, 0, 0, 0), "stepLd10");
      applyStimulus(mk(1, 10, 0, 1, 11, wHalt, 0, Z, 8, 0, 0, 0), "stepLd11Start");
      for (int i = 0; i < 3; i++) begin
         v = mk(0, 0, 0, 0, 0, 0, 0, C_DATAOE, 10, 1, 0, 0);
         v.step = 1'b0;
         applyStimulus(v, $sformatf("stepHeld%0d", i));
      end
      applyStimulus(mk(0, 0, 0, 0, 0, 0, 0, C_ACE | C_DATAOE, 10, 1, 0, 0), "stepAdvance");
      v = mk(0, 0, 0, 0, 0, 0, 0, Z, 11, 1, 0, 0);
      v.step = 1'b0;
      applyStimulus(v, "stepHalt");
      applyStimulus(mk(0, 0, 0, 0, 0, 0, 0, Z, 11, 0, 1, 0), "stepDone");
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
